// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment decode table,
// the all-off pattern and the supported digit count ceiling.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam int   MAX_DIGITS = 8;
    localparam seg_t SEG_OFF    = 7'h7F;

    // Active-low a..g (a is MSB), indexed by hex nibble.
    localparam seg_t SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0D,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Datapath-side inputs and board-side display pins of the scan driver.
interface sevenseg_scan_driver_if
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz_blank;
    seg_t                    drivers;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    frame_done;

    modport master (
        output value, load, blank, dp, lz_blank,
        input  drivers, dp_n, anodes, frame_done
    );

    modport slave (
        input  value, load, blank, dp, lz_blank,
        output drivers, dp_n, anodes, frame_done
    );

endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       segs
);

    assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode display scanner with shadowed content,
// anti-ghosting blank interval, blanking, decimal points and zero suppression.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sevenseg_scan_driver_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    seg_t                    drivers_q, drivers_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    frame_done_q, frame_done_d;

    logic       wrap;
    logic       ghost;
    logic       upper_nz;
    logic       suppress;
    logic [3:0] nibble;
    seg_t       seg;

    generate
        if (GHOST_CYCLES == 0) begin : g_no_ghost
            assign ghost = 1'b0;
        end else begin : g_ghost
            assign ghost = (pre_q < PRE_W'(GHOST_CYCLES));
        end
    endgenerate

    assign nibble = value_q[{idx_q, 2'b00} +: 4];

    sevenseg_hex_decode u_decode (
        .nibble (nibble),
        .segs   (seg)
    );

    always_comb begin
        wrap    = (pre_q == PRE_LAST);
        pre_d   = wrap ? '0 : pre_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        value_d = bus.load ? bus.value : value_q;
        blank_d = bus.load ? bus.blank : blank_q;
        dp_d    = bus.load ? bus.dp    : dp_q;

        // A digit is a leading zero when it and every digit to its left are zero.
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_q)) && (value_q[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        suppress = blank_q[idx_q] |
                   (bus.lz_blank && (idx_q != '0) && !upper_nz);

        anodes_d  = '1;
        drivers_d = SEG_OFF;
        dp_n_d    = 1'b1;
        if (!ghost) begin
            anodes_d[idx_q] = 1'b0;
            if (!suppress) begin
                drivers_d = seg;
                dp_n_d    = ~dp_q[idx_q];
            end
        end

        frame_done_d = wrap && (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            idx_q        <= '0;
            value_q      <= '0;
            blank_q      <= '0;
            dp_q         <= '0;
            drivers_q    <= SEG_OFF;
            dp_n_q       <= 1'b1;
            anodes_q     <= '1;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            blank_q      <= blank_d;
            dp_q         <= dp_d;
            drivers_q    <= drivers_d;
            dp_n_q       <= dp_n_d;
            anodes_q     <= anodes_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.drivers    = drivers_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.anodes     = anodes_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench: a 4-digit scanner plus a 1-digit and a no-ghost variant.
module tb_sevenseg_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) bm ();
    sevenseg_scan_driver_if #(.NUM_DIGITS(1)) ba ();
    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) bb ();

    sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(20), .GHOST_CYCLES(2))
        dut (.clk(clk), .rst_n(rst_n), .bus(bm));
    sevenseg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(10), .GHOST_CYCLES(3))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GHOST_CYCLES(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    logic [6:0] main_seg [4] = '{7'h38, 7'h06, 7'h08, 7'h4F};
    logic [6:0] b_seg    [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_slot(input int n, input logic [3:0] an, input logic [6:0] drv,
                              input logic dpn);
        run_to(n);
        chk($sformatf("anodes@%0d", n), bm.anodes, an);
        chk($sformatf("drivers@%0d", n), bm.drivers, drv);
        chk($sformatf("dp_n@%0d", n), bm.dp_n, dpn);
    endtask

    // Expected outputs after edge n of the 1A3F scan frame for all three instances.
    task automatic check_cycle(input int n);
        int p, s, pa, sb;
        logic [3:0] ea, eb;
        logic [6:0] ed;
        p  = (n - 1) % 20;
        s  = ((n - 1) / 20) % 4;
        pa = (n - 1) % 10;
        sb = ((n - 1) / 8) % 4;
        ea = 4'hF;
        ed = 7'h7F;
        if (p >= 2) begin
            ea[s] = 1'b0;
            ed    = main_seg[s];
        end
        chk($sformatf("scan_anodes@%0d", n), bm.anodes, ea);
        chk($sformatf("scan_drivers@%0d", n), bm.drivers, ed);
        chk($sformatf("scan_dp_n@%0d", n), bm.dp_n, 1'b1);
        chk($sformatf("scan_frame@%0d", n), bm.frame_done, (n % 80 == 0));
        chk($sformatf("n1_anode@%0d", n), ba.anodes, (pa < 3));
        chk($sformatf("n1_frame@%0d", n), ba.frame_done, (n % 10 == 0));
        eb = 4'hF;
        eb[sb] = 1'b0;
        chk($sformatf("g0_anodes@%0d", n), bb.anodes, eb);
        chk($sformatf("g0_frame@%0d", n), bb.frame_done, (n % 32 == 0));
        if (n >= 2) begin
            chk($sformatf("n1_drivers@%0d", n), ba.drivers, (pa < 3) ? 7'h7F : 7'h0D);
            chk($sformatf("g0_drivers@%0d", n), bb.drivers, b_seg[sb]);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bm.value    = '0;
        bm.load     = 1'b0;
        bm.blank    = '0;
        bm.dp       = '0;
        bm.lz_blank = 1'b0;
        ba.value    = 4'h7;
        ba.load     = 1'b1;
        ba.blank    = '0;
        ba.dp       = '0;
        ba.lz_blank = 1'b0;
        bb.value    = 16'h1234;
        bb.load     = 1'b1;
        bb.blank    = '0;
        bb.dp       = '0;
        bb.lz_blank = 1'b0;

        #12;
        chk("por_drivers", bm.drivers, 7'h7F);
        chk("por_anodes", bm.anodes, 4'hF);
        chk("por_dp_n", bm.dp_n, 1'b1);
        chk("por_frame", bm.frame_done, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(2);
        chk("rel_ghost_anodes", bm.anodes, 4'hF);
        run_to(3);
        chk("rel_digit0_anodes", bm.anodes, 4'hE);
        chk("rel_digit0_drivers", bm.drivers, 7'h01);
        run_to(30);
        chk("mid_anodes", bm.anodes, 4'hD);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drivers", bm.drivers, 7'h7F);
        chk("async_anodes", bm.anodes, 4'hF);
        chk("async_dp_n", bm.dp_n, 1'b1);
        chk("async_frame", bm.frame_done, 1'b0);

        bm.value = 16'h1A3F;
        bm.load  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        bm.load = 1'b0;
        check_cycle(1);
        while (cyc < 161) begin
            tick();
            check_cycle(cyc);
        end

        bm.value    = 16'h0005;
        bm.lz_blank = 1'b1;
        bm.load     = 1'b1;
        tick();
        bm.load = 1'b0;
        check_slot(180, 4'hE, 7'h24, 1'b1);
        check_slot(200, 4'hD, 7'h7F, 1'b1);
        check_slot(220, 4'hB, 7'h7F, 1'b1);
        check_slot(240, 4'h7, 7'h7F, 1'b1);

        bm.value = 16'h0000;
        bm.load  = 1'b1;
        tick();
        bm.load = 1'b0;
        check_slot(260, 4'hE, 7'h01, 1'b1);
        check_slot(280, 4'hD, 7'h7F, 1'b1);
        bm.lz_blank = 1'b0;
        check_slot(300, 4'hB, 7'h01, 1'b1);

        bm.value = 16'h4321;
        bm.blank = 4'b0010;
        bm.dp    = 4'b0110;
        bm.load  = 1'b1;
        tick();
        bm.load = 1'b0;
        check_slot(320, 4'h7, 7'h4C, 1'b1);
        check_slot(340, 4'hE, 7'h4F, 1'b1);
        check_slot(360, 4'hD, 7'h7F, 1'b1);
        check_slot(380, 4'hB, 7'h06, 1'b0);

        bm.value = 16'hFFFF;
        bm.blank = 4'b0000;
        bm.dp    = 4'b0000;
        check_slot(400, 4'h7, 7'h4C, 1'b1);
        check_slot(420, 4'hE, 7'h4F, 1'b1);
        check_slot(440, 4'hD, 7'h7F, 1'b1);
        check_slot(460, 4'hB, 7'h06, 1'b0);

        run_to(479);
        bm.value = 16'h000E;
        bm.load  = 1'b1;
        tick();
        bm.load = 1'b0;
        chk("wrap_old_anodes", bm.anodes, 4'h7);
        chk("wrap_old_drivers", bm.drivers, 7'h4C);
        chk("wrap_frame", bm.frame_done, 1'b1);
        run_to(482);
        chk("wrap_ghost", bm.anodes, 4'hF);
        check_slot(483, 4'hE, 7'h30, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a shadow copy of the display value and scans one digit per refresh slot, driving active-low segments and anodes. Each slot starts with an anti-ghosting blank interval. Per-digit blanking, decimal points, leading-zero suppression and a frame-complete strobe are included. It sits between the datapath that produces hex values and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= GHOST_CYCLES+1.
- GHOST_CYCLES, 16, cycles at the start of each slot with all anodes off; 0 disables the interval.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  4*NUM_DIGITS  hex digits; nibble i (bits 4i+3..4i) is digit i, and digit 0 is rightmost.
- load  input  1  when high, value, blank and dp are captured into the shadow registers at the rising edge.
- blank  input  NUM_DIGITS  per-digit force-off; captured by load.
- dp  input  NUM_DIGITS  per-digit decimal point request, active-high; captured by load.
- lz_blank  input  1  leading-zero suppression enable; live input, not shadowed.
- drivers  output  7  segments a..g, a is MSB, active-low (0 = lit).
- dp_n  output  1  decimal point segment, active-low.
- anodes  output  NUM_DIGITS  digit enables, active-low; at most one bit is low at any time.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Reset values: drivers=7'h7F, dp_n=1, anodes=all ones, frame_done=0. The shadow value, blank, dp, prescaler and digit index all reset to 0.
- Shadow registers: display content comes only from the shadow registers. A value captured by load is visible from the next output update. Changing value without load has no effect.
- Prescaler: counts 0..REFRESH_DIV-1 and then wraps to 0. On the wrap, the digit index advances, and index NUM_DIGITS-1 wraps to 0.
- frame_done: asserted for the single cycle in which the prescaler wraps while the index is NUM_DIGITS-1.
- Slot output, with prescaler < GHOST_CYCLES: anodes all ones, drivers=7'h7F, dp_n=1.
- Slot output, otherwise: anodes has only bit index low, and drivers shows the decoded nibble for digit index, unless that digit is suppressed.
- Decode table (hex of drivers[6:0]): 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0D 8:00 9:04 A:08 B:60 C:31 D:42 E:30 F:38.
- Suppression: digit i is suppressed if shadow blank[i]=1. It is also suppressed if lz_blank=1, i>0, and nibbles i..NUM_DIGITS-1 of the shadow are all zero. Digit 0 is never suppressed by lz_blank.
- Suppressed digit: drivers=7'h7F and dp_n=1; its anode is still driven low in its slot.
- Decimal point: when the digit is not suppressed, dp_n = ~shadow dp[index].
- NUM_DIGITS=1: the index stays at 0, and frame_done pulses on every prescaler wrap.

## Timing
- All outputs are registered. The outputs at cycle t+1 are a function of the prescaler, index and shadow state at cycle t.
- Load latency: with load high at edge k, the new shadow is in place after edge k. The outputs reflect it after edge k+1, provided the current slot is past its ghost interval.
- lz_blank is sampled with one cycle of latency, in the same way.
- Slot period is exactly REFRESH_DIV cycles, and the frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load coinciding with a slot wrap: the new digit shows the newly loaded data. There is no mixed-frame ordering requirement beyond this.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously). After release, scanning restarts at digit 0 with prescaler 0, beginning with the ghost interval.

## Structure
- Package sevenseg_pkg holds:
  - the 16-entry decode constant table;
  - SEG_OFF=7'h7F;
  - the maximum digit count, 8.
- Sub-module sevenseg_hex_decode: purely combinational, 4-bit nibble in, 7-bit active-low segments out, built on the package table.
- Top level holds the prescaler, index counter, shadow registers, suppression logic, output registers and frame strobe.

## Test plan
- Reset: assert rst_n=0 mid-slot. Expect drivers=7'h7F, anodes=4'hF, dp_n=1, frame_done=0 with no clock edge. After release, digit 0 is enabled at cycle GHOST_CYCLES+1.
- Scan, with NUM_DIGITS=4, REFRESH_DIV=20, GHOST_CYCLES=2: load value=16'h1A3F, then observe a full frame. Expect:
  - anodes cycle E, D, B, 7;
  - drivers 38, 06, 08, 4F in slots 0..3;
  - anodes all ones for 2 cycles at each slot start;
  - frame_done exactly once every 80 cycles.
- Leading zeros: load value=16'h0005 with lz_blank=1. Expect digits 1..3 at 7'h7F and digit 0 at 7'h24. Load value=16'h0000: digit 0 shows 7'h01.
- Blank and dp: load blank=4'b0010, dp=4'b0110. Expect:
  - digit 1 at 7'h7F with dp_n=1 (blank overrides dp);
  - digit 2 with dp_n=0;
  - digits 0 and 3 with dp_n=1.
- Shadow isolation: change value without load across a full frame and expect the outputs unchanged. Pulse load on the prescaler wrap cycle and expect the incoming digit to show the new nibble.
- Parameter corners: NUM_DIGITS=1 gives anodes constantly 0 outside the ghost interval and frame_done every REFRESH_DIV cycles. GHOST_CYCLES=0 gives no all-off cycles.
